transport_sequencer: RTL and testbench

TRANSPORT_SEQUENCER -- requirements
Module: transport_sequencer

---
 rtl/transport_sequencer.sv | 168 ++++++++++++++++
 tb/tb_transport_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/transport_sequencer.sv
// transport_sequencer: record/overdub/playback address sequencer for a loop RAM.
// Tracks the transport state and drives the sequence RAM address and write enable.
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   rec        record button level, already synchronized to clk
//   play_en    replay enable level
//   step_tick  one-cycle step strobe
//   clear      one-cycle pulse that erases the loop
//   addr       sequence RAM address
//   wr_en      sequence RAM write enable, high exactly while in RECORD
//   loop_end   highest recorded address
//   state      EMPTY=0, IDLE=1, RECORD=2, PLAY=3
//   loop_wrap  one-cycle pulse when playback returns to address 0
//   rec_done   one-cycle pulse on leaving RECORD
//   full       a recording reached MAX_ADDR; sticky until clear or reset
module transport_sequencer #(
   parameter int unsigned ADDR_W   = 11,
   parameter int unsigned MAX_ADDR = 2**ADDR_W - 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rec,
   input  logic              play_en,
   input  logic              step_tick,
   input  logic              clear,
   output logic [ADDR_W-1:0] addr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] loop_end,
   output logic [1:0]        state,
   output logic              loop_wrap,
   output logic              rec_done,
   output logic              full
);

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_IDLE   = 2'd1,
      ST_RECORD = 2'd2,
      ST_PLAY   = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] loop_end_q, loop_end_d;
   logic              full_q, full_d;
   logic              loop_wrap_q, loop_wrap_d;
   logic              rec_done_q, rec_done_d;
   logic              wr_en_q;
   logic              rec_q;
   logic              armed_q;
   logic              rec_rise;
   logic [ADDR_W-1:0] addr_inc;

   // armed_q masks the first cycle after reset so a rec already held high is not an edge
   assign rec_rise = rec & ~rec_q & armed_q;
   assign addr_inc = addr_q + ADDR_W'(1);

   // Next-state and next-output logic; clear outranks everything, a state change never steps addr
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      loop_end_d  = loop_end_q;
      full_d      = full_q;
      loop_wrap_d = 1'b0;
      rec_done_d  = 1'b0;

      if (clear) begin
         state_d    = ST_EMPTY;
         addr_d     = '0;
         loop_end_d = '0;
         full_d     = 1'b0;
         rec_done_d = (state_q == ST_RECORD);
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (rec_rise) begin
                  state_d    = ST_RECORD;
                  addr_d     = '0;
                  loop_end_d = '0;
               end
            end

            ST_RECORD: begin
               if (!rec) begin
                  rec_done_d = 1'b1;
                  addr_d     = '0;
                  state_d    = play_en ? ST_PLAY : ST_IDLE;
               end else if (step_tick) begin
                  if (addr_q < MAX_A) begin
                     addr_d = addr_inc;
                     // overdub beyond the old end extends the loop; it never shrinks
                     if (addr_inc > loop_end_q) begin
                        loop_end_d = addr_inc;
                     end
                  end else begin
                     full_d = 1'b1;
                  end
               end
            end

            ST_IDLE: begin
               if (rec_rise) begin
                  state_d = ST_RECORD;
               end else if (play_en) begin
                  state_d = ST_PLAY;
               end
            end

            ST_PLAY: begin
               if (rec_rise) begin
                  state_d = ST_RECORD;
               end else if (!play_en) begin
                  state_d = ST_IDLE;
               end else if (step_tick) begin
                  // >= keeps addr inside the loop even if it were ever past loop_end
                  if (addr_q >= loop_end_q) begin
                     addr_d      = '0;
                     loop_wrap_d = 1'b1;
                  end else begin
                     addr_d = addr_inc;
                  end
               end
            end

            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_EMPTY;
         addr_q      <= '0;
         loop_end_q  <= '0;
         full_q      <= 1'b0;
         loop_wrap_q <= 1'b0;
         rec_done_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         rec_q       <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         loop_end_q  <= loop_end_d;
         full_q      <= full_d;
         loop_wrap_q <= loop_wrap_d;
         rec_done_q  <= rec_done_d;
         wr_en_q     <= (state_d == ST_RECORD);
         rec_q       <= rec;
         armed_q     <= 1'b1;
      end
   end

   assign addr      = addr_q;
   assign wr_en     = wr_en_q;
   assign loop_end  = loop_end_q;
   assign state     = 2'(state_q);
   assign loop_wrap = loop_wrap_q;
   assign rec_done  = rec_done_q;
   assign full      = full_q;

endmodule

// File: tb/tb_transport_sequencer.sv
// Directed bench for transport_sequencer with ADDR_W=4 (MAX_ADDR=15).
module tb_transport_sequencer;

   logic       clk;
   logic       reset;
   logic       rec;
   logic       play_en;
   logic       step_tick;
   logic       clear;
   logic [3:0] addr;
   logic       wr_en;
   logic [3:0] loop_end;
   logic [1:0] state;
   logic       loop_wrap;
   logic       rec_done;
   logic       full;

   int vectors;
   int miscompares;

   transport_sequencer #(.ADDR_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .rec       (rec),
      .play_en   (play_en),
      .step_tick (step_tick),
      .clear     (clear),
      .addr      (addr),
      .wr_en     (wr_en),
      .loop_end  (loop_end),
      .state     (state),
      .loop_wrap (loop_wrap),
      .rec_done  (rec_done),
      .full      (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input int st, input int ad, input int le,
                             input int we, input int lw, input int rd, input int fl);
      check({tag, ".state"},     32'(state),     st);
      check({tag, ".addr"},      32'(addr),      ad);
      check({tag, ".loop_end"},  32'(loop_end),  le);
      check({tag, ".wr_en"},     32'(wr_en),     we);
      check({tag, ".loop_wrap"}, 32'(loop_wrap), lw);
      check({tag, ".rec_done"},  32'(rec_done),  rd);
      check({tag, ".full"},      32'(full),      fl);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset     = 1'b1;
      rec       = 1'b0;
      play_en   = 1'b0;
      step_tick = 1'b0;
      clear     = 1'b0;

      // reset state
      #1 reset = 1'b0;
      #1 expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      tick(); expect_out("post_reset", 0, 0, 0, 0, 0, 0, 0);

      // basic record: 5 steps then rec low with play_en=0
      rec = 1'b1;
      tick(); expect_out("rec_start", 2, 0, 0, 1, 0, 0, 0);
      step_tick = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick(); expect_out("rec_step", 2, i, i, 1, 0, 0, 0);
      end
      step_tick = 1'b0;
      rec = 1'b0;
      tick(); expect_out("rec_stop", 1, 0, 5, 0, 0, 1, 0);
      tick(); expect_out("idle", 1, 0, 5, 0, 0, 0, 0);

      // playback wrap: 1,2,3,4,5,0,1
      play_en = 1'b1;
      tick(); expect_out("play_enter", 3, 0, 5, 0, 0, 0, 0);
      step_tick = 1'b1;
      for (int i = 0; i < 7; i++) begin
         int ea;
         ea = (i + 1) % 6;
         tick(); expect_out("play_wrap", 3, ea, 5, 0, (ea == 0) ? 1 : 0, 0, 0);
      end

      // overdub from addr 3 extends the loop to 7
      tick(); expect_out("play_to2", 3, 2, 5, 0, 0, 0, 0);
      tick(); expect_out("play_to3", 3, 3, 5, 0, 0, 0, 0);
      step_tick = 1'b0;
      rec = 1'b1;
      tick(); expect_out("overdub_enter", 2, 3, 5, 1, 0, 0, 0);
      step_tick = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         int ea;
         ea = 3 + i;
         tick(); expect_out("overdub_step", 2, ea, (ea > 5) ? ea : 5, 1, 0, 0, 0);
      end
      step_tick = 1'b0;
      rec = 1'b0;
      tick(); expect_out("overdub_exit", 3, 0, 7, 0, 0, 1, 0);

      // clear with rec_rise and step_tick in PLAY
      step_tick = 1'b1;
      tick(); expect_out("play_step", 3, 1, 7, 0, 0, 0, 0);
      clear = 1'b1;
      rec = 1'b1;
      tick(); expect_out("clear_play", 0, 0, 0, 0, 0, 0, 0);
      clear = 1'b0;
      tick(); expect_out("empty_ignore", 0, 0, 0, 0, 0, 0, 0);
      rec = 1'b0;
      tick(); expect_out("empty_rec_low", 0, 0, 0, 0, 0, 0, 0);
      rec = 1'b1;
      tick(); expect_out("rec_no_step", 2, 0, 0, 1, 0, 0, 0);
      tick(); expect_out("rec_first_step", 2, 1, 1, 1, 0, 0, 0);
      step_tick = 1'b0;
      clear = 1'b1;
      tick(); expect_out("clear_rec", 0, 0, 0, 0, 0, 1, 0);
      clear = 1'b0;
      rec = 1'b0;
      tick(); expect_out("after_clear", 0, 0, 0, 0, 0, 0, 0);

      // full: 20 steps from EMPTY saturate at 15
      rec = 1'b1;
      tick(); expect_out("full_start", 2, 0, 0, 1, 0, 0, 0);
      step_tick = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         int ea;
         ea = (i > 15) ? 15 : i;
         tick(); expect_out("full_step", 2, ea, ea, 1, 0, 0, (i >= 16) ? 1 : 0);
      end
      step_tick = 1'b0;
      clear = 1'b1;
      tick(); expect_out("full_clear", 0, 0, 0, 0, 0, 1, 0);
      clear = 1'b0;
      rec = 1'b0;
      tick(); expect_out("full_cleared", 0, 0, 0, 0, 0, 0, 0);

      // reset mid-record at addr 6
      rec = 1'b1;
      tick(); expect_out("rst_rec_start", 2, 0, 0, 1, 0, 0, 0);
      step_tick = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
      end
      expect_out("rst_at6", 2, 6, 6, 1, 0, 0, 0);
      step_tick = 1'b0;
      #2 reset = 1'b0;
      #1 expect_out("reset_async", 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      expect_out("reset_hold", 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      tick(); expect_out("release_rec_high", 0, 0, 0, 0, 0, 0, 0);
      tick(); expect_out("release_rec_high2", 0, 0, 0, 0, 0, 0, 0);

      // PLAY with loop_end 0 wraps on every step
      rec = 1'b0;
      tick();
      rec = 1'b1;
      tick(); expect_out("zero_rec", 2, 0, 0, 1, 0, 0, 0);
      rec = 1'b0;
      tick(); expect_out("zero_play", 3, 0, 0, 0, 0, 1, 0);
      step_tick = 1'b1;
      tick(); expect_out("zero_wrap1", 3, 0, 0, 0, 1, 0, 0);
      tick(); expect_out("zero_wrap2", 3, 0, 0, 0, 1, 0, 0);
      step_tick = 1'b0;
      play_en = 1'b0;
      tick(); expect_out("zero_idle", 1, 0, 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
